// File: rtl/pc_fetch_unit.sv
// Program-counter register and req/ack instruction-fetch sequencer (IDLE/FETCH/EXEC/HALT).
// Optional feature macro: PC_ALIGN_CHECK_EN (halt with a sticky misalign flag on an unaligned next_pc).
module pc_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              halt_req,
    output logic              halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
`ifdef PC_ALIGN_CHECK_EN
    logic                misalign_q, misalign_d;
`endif

    // Next-state and datapath update rules; only FETCH captures memory data, only EXEC commits.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (stall) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef PC_ALIGN_CHECK_EN
                    // An unaligned target halts with pc left on the committing instruction.
                    if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = halt_req ? ST_HALT : ST_FETCH;
                    end
`else
                    pc_d    = next_pc & ALIGN_MASK;
                    state_d = halt_req ? ST_HALT : ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= {DATA_W{1'b0}};
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Outputs are pure decodes of registers, so reset clears them without waiting for a clock.
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign imem_req    = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign halted      = (state_q == ST_HALT);
`ifdef PC_ALIGN_CHECK_EN
    assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: transaction-level model compared every cycle plus directed literals.
module tb_pc_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              stall;
    logic              halt_req;
    logic              halted;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .stall       (stall),
        .halt_req    (halt_req),
        .halted      (halted)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch unit is doing, as a phase plus the architectural values.
    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_HALT  = 3;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_mis;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = PH_IDLE;
            m_pc    = RESET_PC;
            m_instr = 32'h0;
            m_mis   = 1'b0;
        end else if (m_phase == PH_IDLE) begin
            m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_phase = PH_EXEC;
            end
        end else if (m_phase == PH_EXEC && !stall) begin
`ifdef PC_ALIGN_CHECK_EN
            if (next_pc % 4 != 0) begin
                m_mis   = 1'b1;
                m_phase = PH_HALT;
            end else begin
                m_pc    = next_pc;
                m_phase = halt_req ? PH_HALT : PH_FETCH;
            end
`else
            m_pc    = next_pc - (next_pc % 4);
            m_phase = halt_req ? PH_HALT : PH_FETCH;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_pc",    pc,                   m_pc);
            chk("m_addr",  imem_addr,            m_pc);
            chk("m_req",   {31'b0, imem_req},    {31'b0, m_phase == PH_FETCH});
            chk("m_valid", {31'b0, instr_valid}, {31'b0, m_phase == PH_EXEC});
            chk("m_halt",  {31'b0, halted},      {31'b0, m_phase == PH_HALT});
            chk("m_instr", instr,                m_instr);
`ifdef PC_ALIGN_CHECK_EN
            chk("m_mis",   {31'b0, misalign},    {31'b0, m_mis});
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_v;
        rst        = 1'b1;
        next_pc    = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        halt_req   = 1'b0;
        #1;
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_req",   {31'b0, imem_req},    32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_halt",  {31'b0, halted},      32'h0);
        chk("rst_instr", instr,                32'h0);
        step();
        step();

        // 1: same-cycle ack
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2000_0000;
        step();
        chk("t1_req",  {31'b0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr,         32'h0);
        step();
        chk("t1_valid", {31'b0, instr_valid}, 32'h1);
        chk("t1_instr", instr,                32'h2000_0000);
        imem_ack = 1'b0;
        next_pc  = 32'h4;
        step();
        chk("t1_addr2", imem_addr, 32'h4);

        // 2: ack delayed 3 cycles
        for (int i = 0; i < 4; i++) begin
            chk("t2_req",   {31'b0, imem_req},    32'h1);
            chk("t2_addr",  imem_addr,            32'h4);
            chk("t2_valid", {31'b0, instr_valid}, 32'h0);
            if (i == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h1111_1111;
            end
            step();
        end
        chk("t2_valid_after", {31'b0, instr_valid}, 32'h1);
        chk("t2_instr",       instr,                32'h1111_1111);
        imem_ack = 1'b0;
        next_pc  = 32'h8;
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_2222;
        step();

        // 3: branch from 0x8 to 0x40
        chk("t3_pc_exec", pc, 32'h8);
        imem_ack = 1'b0;
        next_pc  = 32'h40;
        step();
        chk("t3_addr", imem_addr, 32'h40);
        chk("t3_pc",   pc,        32'h40);

        // 4: two stall cycles, commit on the third edge
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_3333;
        step();
        imem_ack = 1'b0;
        stall    = 1'b1;
        next_pc  = 32'h44;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t4_valid", {31'b0, instr_valid}, 32'h1);
            chk("t4_instr", instr,                32'h3333_3333);
            chk("t4_pc",    pc,                   32'h40);
            chk("t4_req",   {31'b0, imem_req},    32'h0);
        end
        stall = 1'b0;
        step();
        chk("t4_commit_pc", pc,                32'h44);
        chk("t4_commit_rq", {31'b0, imem_req}, 32'h1);

        // 5: stall+halt_req delays the halt until the commit
        imem_ack   = 1'b1;
        imem_rdata = 32'h4444_4444;
        step();
        imem_ack = 1'b0;
        stall    = 1'b1;
        halt_req = 1'b1;
        next_pc  = 32'h48;
        step();
        chk("t5_not_halted", {31'b0, halted},      32'h0);
        chk("t5_still_exec", {31'b0, instr_valid}, 32'h1);
        stall = 1'b0;
        step();
        chk("t5_halted", {31'b0, halted}, 32'h1);
        chk("t5_pc",     pc,              32'h48);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i % 2 == 0);
            step();
            chk("t5_req",    {31'b0, imem_req}, 32'h0);
            chk("t5_sticky", {31'b0, halted},   32'h1);
            chk("t5_pc_frz", pc,                32'h48);
        end
        imem_ack = 1'b0;

        // 6: reset clears halt, then reset mid-FETCH with a late ack after release
        rst = 1'b1;
        #1;
        chk("t6_rst_halt", {31'b0, halted}, 32'h0);
        chk("t6_rst_pc",   pc,              RESET_PC);
        step();
        rst = 1'b0;
        step();
        chk("t6_fetch_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_async_req", {31'b0, imem_req}, 32'h0);
        chk("t6_async_pc",  pc,                RESET_PC);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        rst = 1'b0;
        step();
        chk("t6_late_ack_instr", instr,                32'h0);
        chk("t6_late_ack_valid", {31'b0, instr_valid}, 32'h0);
        chk("t6_late_ack_req",   {31'b0, imem_req},    32'h1);
        imem_rdata = 32'h5555_5555;
        step();
        chk("t6_instr", instr, 32'h5555_5555);
        imem_ack = 1'b0;
        next_pc  = 32'h42;
        step();
`ifdef PC_ALIGN_CHECK_EN
        chk("t6_misalign", {31'b0, misalign},  32'h1);
        chk("t6_halted",   {31'b0, halted},    32'h1);
        chk("t6_pc_keep",  pc,                 32'h0);
        chk("t6_req",      {31'b0, imem_req},  32'h0);
`else
        chk("t6_align_addr", imem_addr,         32'h40);
        chk("t6_align_req",  {31'b0, imem_req}, 32'h1);
        chk("t6_halted",     {31'b0, halted},   32'h0);

        // pc wraps modulo 2^32
        imem_ack   = 1'b1;
        imem_rdata = 32'h6666_6666;
        step();
        imem_ack = 1'b0;
        next_pc  = 32'hFFFF_FFFC;
        step();
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h7777_7777;
        step();
        imem_ack = 1'b0;
        pc_v     = 32'hFFFF_FFFC;
        next_pc  = pc_v + 32'h4;
        step();
        chk("wrap_pc",  pc,                32'h0);
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
`endif
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
